// File: rtl/rr_encoder_arbiter.sv
`default_nettype none
// ---------------------------------------------------------------------------
// rr_encoder_arbiter : 4-way round-robin arbiter with hold timeout and grant counter
// Rev 1.0
// ---------------------------------------------------------------------------
module rr_encoder_arbiter #(
  parameter int MAX_HOLD = 8,
  parameter int CNT_W    = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [3:0]       req,
  input  logic             done,
  output logic [3:0]       gnt,
  output logic [1:0]       gnt_idx,
  output logic             gnt_valid,
  output logic             timeout,
  output logic [CNT_W-1:0] grant_count
);

  typedef enum logic [0:0] {
    IDLE  = 1'b0,
    GRANT = 1'b1
  } state_t;

  localparam logic [7:0]       HOLD_LIMIT = 8'(MAX_HOLD);
  localparam logic [CNT_W-1:0] CNT_SAT    = '1;

  state_t           state, state_nxt;
  logic [1:0]       ptr, ptr_nxt;
  logic [7:0]       hold_cnt, hold_nxt;
  logic [3:0]       gnt_nxt;
  logic [1:0]       idx_nxt;
  logic             valid_nxt;
  logic             timeout_nxt;
  logic [CNT_W-1:0] count_nxt;

  logic [7:0]       req_dbl;
  logic [3:0]       req_rot;
  logic [1:0]       win_off;
  logic [1:0]       win_idx;
  logic             rel_drop;
  logic             rel_hold;

  // Rotate the request vector so bit 0 is the requester at ptr; then a fixed
  // priority pick on the rotated vector gives the round-robin winner.
  assign req_dbl = {req, req};
  assign req_rot = req_dbl[ptr +: 4];

  always_comb begin
    if (req_rot[0])      win_off = 2'd0;
    else if (req_rot[1]) win_off = 2'd1;
    else if (req_rot[2]) win_off = 2'd2;
    else                 win_off = 2'd3;
  end

  assign win_idx  = ptr + win_off;
  assign rel_drop = ~req[gnt_idx];
  assign rel_hold = (hold_cnt == HOLD_LIMIT);

  always_comb begin
    state_nxt   = state;
    ptr_nxt     = ptr;
    hold_nxt    = hold_cnt;
    gnt_nxt     = gnt;
    idx_nxt     = gnt_idx;
    valid_nxt   = gnt_valid;
    timeout_nxt = 1'b0;
    count_nxt   = grant_count;
    case (state)
      IDLE: begin
        if (|req) begin
          state_nxt = GRANT;
          gnt_nxt   = 4'b0001 << win_idx;
          idx_nxt   = win_idx;
          valid_nxt = 1'b1;
          hold_nxt  = 8'd1;
          if (grant_count != CNT_SAT) count_nxt = grant_count + 1'b1;
        end
      end
      GRANT: begin
        if (done || rel_drop || rel_hold) begin
          state_nxt   = IDLE;
          gnt_nxt     = 4'b0000;
          idx_nxt     = 2'd0;
          valid_nxt   = 1'b0;
          hold_nxt    = 8'd0;
          ptr_nxt     = gnt_idx + 2'd1;
          // Only a pure hold expiry is reported as a forced release.
          timeout_nxt = rel_hold && !done && !rel_drop;
        end else begin
          hold_nxt = hold_cnt + 8'd1;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nxt;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ptr         <= 2'd0;
      hold_cnt    <= 8'd0;
      gnt         <= 4'b0000;
      gnt_idx     <= 2'd0;
      gnt_valid   <= 1'b0;
      timeout     <= 1'b0;
      grant_count <= '0;
    end else begin
      ptr         <= ptr_nxt;
      hold_cnt    <= hold_nxt;
      gnt         <= gnt_nxt;
      gnt_idx     <= idx_nxt;
      gnt_valid   <= valid_nxt;
      timeout     <= timeout_nxt;
      grant_count <= count_nxt;
    end
  end

endmodule
`default_nettype wire
